// File: rtl/iir_host_pkg.sv
// iir_host_pkg: shared types and defaults for the IIR sample host.
//   state_t      : host FSM state (IDLE/RUN/WAIT/DONE), 2-bit encoding
//   ADDR_W_DEF   : default filter address width
//   DATA_W_DEF   : default sample/result width
//   n_valid()    : sample count range check, 1..2**depth_log2
package iir_host_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic n_valid(input int unsigned n, input int unsigned depth_log2);
    return (n != 0) && (n <= (32'd1 << depth_log2));
  endfunction

endpackage

// File: rtl/iir_sample_host_if.sv
// iir_sample_host_if: sample bus between the IIR core and its memory host.
//   master : filter core side (drives load/raddr/wen/waddr/yn/finish)
//   slave  : host side (drives din/data_done/flt_rst)
interface iir_sample_host_if
  import iir_host_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              flt_rst;
  logic              flt_load;
  logic [ADDR_W-1:0] flt_raddr;
  logic [DATA_W-1:0] flt_din;
  logic              flt_wen;
  logic [ADDR_W-1:0] flt_waddr;
  logic [DATA_W-1:0] flt_yn;
  logic              flt_data_done;
  logic              flt_finish;

  modport master (
    input  flt_rst, flt_din, flt_data_done,
    output flt_load, flt_raddr, flt_wen, flt_waddr, flt_yn, flt_finish
  );

  modport slave (
    output flt_rst, flt_din, flt_data_done,
    input  flt_load, flt_raddr, flt_wen, flt_waddr, flt_yn, flt_finish
  );
endinterface

// File: rtl/iir_host_ram.sv
// iir_host_ram: 2**AW x DW buffer, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
module iir_host_ram
  import iir_host_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/iir_sample_host.sv
// iir_sample_host: memory-side responder for the IIR core's sample bus.
// Holds the input sample buffer and the output result buffer, drives the
// core's reset, serves reads, captures write-backs and detects completion.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_wr_en/addr/data : host sample load (accepted in IDLE only)
//   i_num_samples     : sample count N, latched on an accepted start
//   i_start, i_abort  : run pulse / return to IDLE (abort wins)
//   i_rd_addr         : result readback address
//   o_rd_data         : result readback data, 1-cycle latency
//   o_busy, o_done    : RUN|WAIT, DONE
//   o_err             : sticky error, cleared by rst or an accepted start
//   flt               : filter sample bus (slave side)
//
// Optional: define IIR_HOST_TIMEOUT_EN to add a RUN watchdog that trips
// N+TIMEOUT cycles after start if the core never raises finish.
module iir_sample_host
  import iir_host_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic [DEPTH_LOG2:0]   i_num_samples,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  iir_sample_host_if.slave      flt
);
  state_t                r_state;
  logic [DEPTH_LOG2:0]   r_n, r_cnt;
  logic                  r_flt_rst, r_busy, r_done, r_err;
  logic [DATA_W-1:0]     r_rd_data;
`ifdef IIR_HOST_TIMEOUT_EN
  logic [31:0]           r_tmo;
`endif

  logic [ADDR_W-1:0]     w_n_ext;
  logic                  w_rd_hit, w_cap, w_in_we, w_n_ok;
  logic [DATA_W-1:0]     w_in_q, w_out_q;

  assign w_n_ext  = ADDR_W'(r_n);
  assign w_rd_hit = flt.flt_load && (flt.flt_raddr < w_n_ext);
  // Only in-range write-backs during RUN land in out_mem and count.
  assign w_cap    = (r_state == ST_RUN) && flt.flt_wen && (flt.flt_waddr < w_n_ext);
  assign w_in_we  = (r_state == ST_IDLE) && i_wr_en;
  assign w_n_ok   = n_valid(32'(i_num_samples), DEPTH_LOG2);

  iir_host_ram #(.AW(DEPTH_LOG2), .DW(DATA_W)) u_in_mem (
    .clk     (clk),
    .i_we    (w_in_we),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data),
    .i_raddr (flt.flt_raddr[DEPTH_LOG2-1:0]),
    .o_rdata (w_in_q)
  );

  iir_host_ram #(.AW(DEPTH_LOG2), .DW(DATA_W)) u_out_mem (
    .clk     (clk),
    .i_we    (w_cap),
    .i_waddr (flt.flt_waddr[DEPTH_LOG2-1:0]),
    .i_wdata (flt.flt_yn),
    .i_raddr (i_rd_addr),
    .o_rdata (w_out_q)
  );

  // Registered readback wrapper around out_mem.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= w_out_q;

  assign flt.flt_din       = w_rd_hit ? w_in_q : '0;
  assign flt.flt_data_done = (flt.flt_raddr >= w_n_ext);
  assign flt.flt_rst       = r_flt_rst;

  assign o_rd_data = r_rd_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_flt_rst <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_n       <= '0;
      r_cnt     <= '0;
`ifdef IIR_HOST_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else if (i_abort) begin
      r_state   <= ST_IDLE;
      r_flt_rst <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (i_wr_en && (r_state != ST_IDLE)) r_err <= 1'b1;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            if (w_n_ok) begin
              // Core leaves reset on the same edge the run is accepted.
              r_n       <= i_num_samples;
              r_cnt     <= '0;
              r_err     <= 1'b0;
              r_state   <= ST_RUN;
              r_flt_rst <= 1'b0;
              r_busy    <= 1'b1;
              r_done    <= 1'b0;
`ifdef IIR_HOST_TIMEOUT_EN
              r_tmo     <= '0;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_cap) r_cnt <= r_cnt + 1'b1;
          if (flt.flt_finish) begin
            r_state <= ST_WAIT;
          end
`ifdef IIR_HOST_TIMEOUT_EN
          else if (r_tmo == 32'(r_n) + 32'(TIMEOUT) - 32'd1) begin
            r_err     <= 1'b1;
            r_flt_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
`endif
        end
        ST_WAIT: begin
          // Last write-back landed on the edge into WAIT; count is final.
          if (r_cnt != r_n) r_err <= 1'b1;
          r_state   <= ST_DONE;
          r_flt_rst <= 1'b1;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/iir_sample_host.md
Name: iir_sample_host

Overview:
- Memory-side responder for the IIR filter's sample interface.
- Holds the input sample buffer and the output result buffer.
- Drives filter reset and run control, and serves read addresses with sample data.
- Captures filter write-backs, detects completion and exposes results to a host readback port.
- Sits between the system/host loader and the IIR core.

Parameters:
- ADDR_W, 20: filter address width, flt_raddr/flt_waddr.
- DATA_W, 16: sample and result width, signed two's complement.
- DEPTH_LOG2, 10: log2 of buffer depth; each buffer is 2**DEPTH_LOG2 words.
- TIMEOUT, 64: extra cycles allowed after N before watchdog trip (only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  host sample write strobe
- wr_addr  in  DEPTH_LOG2  host sample write address
- wr_data  in  DATA_W  host sample write data
- num_samples  in  DEPTH_LOG2+1  sample count N, latched on start
- start  in  1  run pulse
- abort  in  1  return to IDLE
- rd_addr  in  DEPTH_LOG2  result readback address
- rd_data  out  DATA_W  result readback data, 1-cycle latency
- busy  out  1  high in RUN and WAIT
- done  out  1  high in DONE
- err  out  1  sticky error flag
- flt_rst  out  1  reset to filter core, registered
- flt_load  in  1  filter read request
- flt_raddr  in  ADDR_W  filter read address
- flt_din  out  DATA_W  sample to filter, combinational
- flt_wen  in  1  filter write strobe
- flt_waddr  in  ADDR_W  filter write address
- flt_yn  in  DATA_W  filter result
- flt_data_done  out  1  end-of-data indication to filter
- flt_finish  in  1  filter completion flag

Behaviour:
- Reset values: state=IDLE, flt_rst=1, busy=0, done=0, err=0, rd_data=0, N=0, capture count=0. Buffer contents are not reset.
- Reset mid-run has the same effect: state returns to IDLE and flt_rst=1, so the filter is held in reset too.
- States: IDLE, RUN, WAIT, DONE.
- IDLE:
  - flt_rst=1.
  - wr_en writes in_mem[wr_addr]<=wr_data.
  - start with num_samples in 1..2**DEPTH_LOG2: latch N, clear capture count, go to RUN, and flt_rst falls on the same edge.
  - start with num_samples=0 or >2**DEPTH_LOG2: set err, stay in IDLE.
- RUN:
  - Filter address counting begins on the first edge after flt_rst falls.
  - flt_din = in_mem[flt_raddr] if flt_load and flt_raddr<N, else 0.
  - flt_wen with flt_waddr<N: out_mem[flt_waddr]<=flt_yn and capture count increments. flt_wen with flt_waddr>=N is ignored.
  - Required sequence for N samples: RAddr=N coincides with the write of index N-1.
  - flt_data_done = (flt_raddr>=N), combinational; the filter registers Finish one cycle later.
  - flt_finish=1 -> WAIT.
- WAIT (one cycle, lets the last write land):
  - If capture count!=N, set err.
  - Go to DONE and assert flt_rst.
- DONE:
  - done=1, flt_rst=1.
  - start re-runs with the same in_mem; N is re-latched.
- Readback: rd_data<=out_mem[rd_addr] every cycle in any state.
- wr_en outside IDLE is ignored and sets err.
- abort in any state -> IDLE with flt_rst=1. abort has priority over start in the same cycle.
- err clears only on rst or on an accepted start.
- Simultaneous flt_finish and abort: abort wins.

Optional Feature:
- Macro IIR_HOST_TIMEOUT_EN.
- Defined: a cycle counter runs in RUN. If it reaches N+TIMEOUT without flt_finish, set err, assert flt_rst and go to DONE.
- Undefined: no counter; RUN waits indefinitely for flt_finish or abort.

Decomposition:
- Package iir_host_pkg: state enum (IDLE/RUN/WAIT/DONE), ADDR_W/DATA_W defaults, state encoding constants.
- Sub-module iir_host_ram: 1 write port plus 1 combinational read port, instantiated for in_mem. out_mem uses the same module with a registered read wrapper.

Test Plan:
- Bench filter stub: yn(k)=din(k-1) with the core's timing. Load N=4 samples 0x0001,0x0002,0x7FFF,0x8000, then start -> out_mem[0..3] equals the same four words, done=1 after flt_finish plus 1 cycle, err=0.
- start with num_samples=0 -> err=1, state stays IDLE, flt_rst stays 1.
- Stub keeps running past N: flt_raddr=N..N+3 -> flt_din=0 and flt_data_done=1; writes to waddr>=N are dropped and out_mem[N] is unchanged.
- abort asserted two cycles into RUN with N=8 -> IDLE next edge, flt_rst=1, busy=0; a following start completes normally.
- Stub drops one write with N=4 -> err=1 in WAIT, done=1.
- With IIR_HOST_TIMEOUT_EN and a stub that never raises finish, N=4, TIMEOUT=64 -> err=1 and DONE reached 68 cycles after start.
